// File: rtl/perf_memsys_snapshot.sv
// Memory-system perf counter snapshot: latches 26 counters coherently, serves indexed 32-bit half reads.
// Latency: read response 1 cycle after request fires; snapshot visible to a request fired the next cycle.
// Backpressure: one-entry response buffer (req_ready = !rsp_valid || rsp_ready); snapshots stall while a response is held.
// Optional build macro PERF_SNAP_DELTA_EN: store per-snapshot deltas instead of absolute values.
module perf_memsys_snapshot #(
    parameter int CTR_BITS   = 44,
    parameter int DATA_WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [26*CTR_BITS-1:0]   perf_memsys,
    input  logic                     snap_valid,
    output logic                     snap_ready,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [4:0]               req_idx,
    input  logic                     req_hi,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [DATA_WIDTH-1:0]    rsp_data,
    output logic                     rsp_err
);

    localparam int NUM_CTRS = 26;

    typedef enum logic {
        ST_EMPTY,
        ST_VALID
    } state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic [CTR_BITS-1:0]    bank [NUM_CTRS];
`ifdef PERF_SNAP_DELTA_EN
    logic [CTR_BITS-1:0]    prev [NUM_CTRS];
`endif
    logic [7:0]             epoch;
    logic                   snap_fire;
    logic                   rd_fire;
    logic [CTR_BITS-1:0]    sel;
    logic [63:0]            sel_ext;
    logic [DATA_WIDTH-1:0]  rd_data;
    logic                   rd_err;

    assign snap_ready = !rsp_valid;
    assign req_ready  = !rsp_valid || rsp_ready;
    assign snap_fire  = snap_valid && snap_ready;
    assign rd_fire    = req_valid && req_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (snap_fire) begin
            state_nxt = ST_VALID;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            epoch <= '0;
            for (int i = 0; i < NUM_CTRS; i++) begin
                bank[i] <= '0;
`ifdef PERF_SNAP_DELTA_EN
                prev[i] <= '0;
`endif
            end
        end else if (snap_fire) begin
            epoch <= epoch + 8'd1;
            for (int i = 0; i < NUM_CTRS; i++) begin
`ifdef PERF_SNAP_DELTA_EN
                // Subtraction at CTR_BITS width gives the modular delta across counter wrap.
                bank[i] <= perf_memsys[i*CTR_BITS +: CTR_BITS] - prev[i];
                prev[i] <= perf_memsys[i*CTR_BITS +: CTR_BITS];
`else
                bank[i] <= perf_memsys[i*CTR_BITS +: CTR_BITS];
`endif
            end
        end
    end

    // Decode reads the bank as it stands this cycle, so a same-cycle snapshot is not yet visible.
    always_comb begin
        sel     = (req_idx < 5'd26) ? bank[req_idx] : '0;
        sel_ext = 64'(sel);
        rd_data = '0;
        rd_err  = 1'b0;
        if (req_idx == 5'd31) begin
            if (!req_hi) begin
                rd_data = {24'b0, epoch};
            end
        end else if (req_idx >= 5'd26 || state == ST_EMPTY) begin
            rd_err = 1'b1;
        end else if (req_hi) begin
            rd_data = sel_ext[63:32];
        end else begin
            rd_data = sel_ext[31:0];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
        end else if (rd_fire) begin
            rsp_valid <= 1'b1;
            rsp_data  <= rd_data;
            rsp_err   <= rd_err;
        end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_perf_memsys_snapshot.sv
// Directed bench for perf_memsys_snapshot (CTR_BITS=44); expectations follow PERF_SNAP_DELTA_EN when defined.
module tb_perf_memsys_snapshot;

    localparam int CB = 44;

    logic              clk;
    logic              reset_n;
    logic [26*CB-1:0]  perf_memsys;
    logic              snap_valid;
    logic              snap_ready;
    logic              req_valid;
    logic              req_ready;
    logic [4:0]        req_idx;
    logic              req_hi;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [31:0]       rsp_data;
    logic              rsp_err;

    int ncmp  = 0;
    int nfail = 0;

    perf_memsys_snapshot #(.CTR_BITS(CB), .DATA_WIDTH(32)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .perf_memsys(perf_memsys),
        .snap_valid (snap_valid),
        .snap_ready (snap_ready),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_idx    (req_idx),
        .req_hi     (req_hi),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_err    (rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_ctr(input int i, input logic [CB-1:0] v);
        perf_memsys[i*CB +: CB] = v;
    endtask

    // Called at a negedge with no response pending; leaves the response drained.
    task automatic do_read(input string tag, input logic [4:0] idx, input logic hi,
                           input logic [31:0] exp_d, input logic exp_e);
        req_valid = 1'b1;
        req_idx   = idx;
        req_hi    = hi;
        rsp_ready = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        check({tag, ".vld"}, 64'(rsp_valid), 64'd1);
        check({tag, ".dat"}, 64'(rsp_data), 64'(exp_d));
        check({tag, ".err"}, 64'(rsp_err), 64'(exp_e));
        @(negedge clk);
    endtask

    task automatic do_snap();
        snap_valid = 1'b1;
        @(negedge clk);
        snap_valid = 1'b0;
    endtask

    initial begin
        reset_n     = 1'b0;
        perf_memsys = '0;
        snap_valid  = 1'b0;
        req_valid   = 1'b0;
        req_idx     = '0;
        req_hi      = 1'b0;
        rsp_ready   = 1'b0;
        repeat (2) @(negedge clk);
        check("rst.rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst.rsp_data", 64'(rsp_data), 64'd0);
        check("rst.rsp_err", 64'(rsp_err), 64'd0);
        check("rst.snap_ready", 64'(snap_ready), 64'd1);
        check("rst.req_ready", 64'(req_ready), 64'd1);
        reset_n = 1'b1;
        @(negedge clk);

        do_read("empty.idx0", 5'd0, 1'b0, 32'h0, 1'b1);
        do_read("empty.idx2hi", 5'd2, 1'b1, 32'h0, 1'b1);
        do_read("empty.idx31", 5'd31, 1'b0, 32'h0, 1'b0);

        set_ctr(2, 44'h123_4567_89AB);
        set_ctr(23, 44'd5);
        set_ctr(25, 44'd100);
        do_snap();
        set_ctr(2, 44'h0AA_0000_0001);
        do_read("snap1.idx2lo", 5'd2, 1'b0, 32'h4567_89AB, 1'b0);
        do_read("snap1.idx2hi", 5'd2, 1'b1, 32'h0000_0123, 1'b0);
        do_read("snap1.idx31", 5'd31, 1'b0, 32'd1, 1'b0);
        do_read("snap1.idx31hi", 5'd31, 1'b1, 32'd0, 1'b0);
        do_read("snap1.idx25", 5'd25, 1'b0, 32'd100, 1'b0);
        do_read("snap1.idx0", 5'd0, 1'b0, 32'd0, 1'b0);
        do_read("snap1.idx28", 5'd28, 1'b0, 32'd0, 1'b1);
        do_read("snap1.idx26hi", 5'd26, 1'b1, 32'd0, 1'b1);

        // Three reads against a stalled consumer.
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        req_idx   = 5'd2;
        req_hi    = 1'b0;
        @(negedge clk);
        check("bp.first.vld", 64'(rsp_valid), 64'd1);
        check("bp.first.dat", 64'(rsp_data), 64'h4567_89AB);
        check("bp.req_ready", 64'(req_ready), 64'd0);
        check("bp.snap_ready", 64'(snap_ready), 64'd0);
        req_idx = 5'd31;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check("bp.hold.vld", 64'(rsp_valid), 64'd1);
            check("bp.hold.dat", 64'(rsp_data), 64'h4567_89AB);
            check("bp.hold.req_ready", 64'(req_ready), 64'd0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        check("bp.second.dat", 64'(rsp_data), 64'd1);
        req_idx = 5'd25;
        @(negedge clk);
        check("bp.third.dat", 64'(rsp_data), 64'd100);
        check("bp.third.vld", 64'(rsp_valid), 64'd1);
        req_valid = 1'b0;
        @(negedge clk);
        check("bp.drained", 64'(rsp_valid), 64'd0);

        // Snapshot and read in the same cycle return pre-snapshot contents.
        set_ctr(23, 44'd9);
        snap_valid = 1'b1;
        req_valid  = 1'b1;
        req_idx    = 5'd23;
        req_hi     = 1'b0;
        @(negedge clk);
        snap_valid = 1'b0;
        req_valid  = 1'b0;
        check("same.dat", 64'(rsp_data), 64'd5);
        check("same.err", 64'(rsp_err), 64'd0);
        @(negedge clk);
`ifdef PERF_SNAP_DELTA_EN
        do_read("same.next", 5'd23, 1'b0, 32'd4, 1'b0);
`else
        do_read("same.next", 5'd23, 1'b0, 32'd9, 1'b0);
`endif
        do_read("epoch2", 5'd31, 1'b0, 32'd2, 1'b0);

        set_ctr(25, 44'd250);
        set_ctr(24, 44'hFFF_FFFF_FFF0);
        do_snap();
`ifdef PERF_SNAP_DELTA_EN
        do_read("lat.delta", 5'd25, 1'b0, 32'd150, 1'b0);
`else
        do_read("lat.abs", 5'd25, 1'b0, 32'd250, 1'b0);
`endif
        do_read("wr.hi", 5'd24, 1'b1, 32'h0000_0FFF, 1'b0);
        set_ctr(24, 44'h10);
        do_snap();
`ifdef PERF_SNAP_DELTA_EN
        do_read("wrap.lo", 5'd24, 1'b0, 32'h20, 1'b0);
`else
        do_read("wrap.lo", 5'd24, 1'b0, 32'h10, 1'b0);
`endif
        do_read("wrap.hi", 5'd24, 1'b1, 32'h0, 1'b0);
        do_read("epoch4", 5'd31, 1'b0, 32'd4, 1'b0);

        snap_valid = 1'b1;
        repeat (251) @(negedge clk);
        snap_valid = 1'b0;
        do_read("epoch255", 5'd31, 1'b0, 32'd255, 1'b0);
        do_snap();
        do_read("epoch.wrap", 5'd31, 1'b0, 32'd0, 1'b0);

        // Reset while a response is held.
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        req_idx   = 5'd2;
        @(negedge clk);
        req_valid = 1'b0;
        check("midrst.pre.vld", 64'(rsp_valid), 64'd1);
        #2 reset_n = 1'b0;
        #1;
        check("midrst.vld", 64'(rsp_valid), 64'd0);
        check("midrst.snap_ready", 64'(snap_ready), 64'd1);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        do_read("midrst.idx2", 5'd2, 1'b0, 32'd0, 1'b1);
        do_read("midrst.idx31", 5'd31, 1'b0, 32'd0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
